// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity generator/checker pair.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic PARITY_EVEN    = 1'b0;
  localparam logic PARITY_ODD_SEL = 1'b1;
  localparam int   ERR_CNT_W      = 8;

endpackage

// File: rtl/parity_accumulator.sv
// Running-XOR parity element: load presets the accumulator, en folds bit_in into it.
module parity_accumulator #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (en) begin
      acc_d = acc_q ^ bit_in;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= RST_VAL;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_parity_frame_checker.sv
// Deserialises start/data/parity/stop frames and reports parity and framing status.
// Optional saturating error counter enabled by defining PARITY_ERR_COUNT_EN.
module serial_parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic             PRELOAD  = 1'(PARITY_ODD);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              frame_valid_q, frame_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              framing_err_q, framing_err_d;
  logic              acc_load;
  logic              acc_en;
  logic              acc;

  parity_accumulator #(
    .RST_VAL (PRELOAD)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .load     (acc_load),
    .load_val (PRELOAD),
    .en       (acc_en),
    .bit_in   (bit_in),
    .acc      (acc)
  );

  // Frame FSM: nothing advances on cycles without bit_valid.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    data_out_d    = data_out_q;
    frame_valid_d = 1'b0;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    acc_load      = 1'b0;
    acc_en        = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d  = DATA;
            shift_d  = '0;
            cnt_d    = '0;
            acc_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bit_in;
          acc_en         = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          acc_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          data_out_d    = shift_q;
          parity_err_d  = acc;
          framing_err_d = ~bit_in;
          frame_valid_d = 1'b1;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Counts with the same edge that raises frame_valid, so the value is current on that cycle.
  always_comb begin
    err_count_d = err_count_q;
    if (frame_valid_d && (parity_err_d || framing_err_d) &&
        (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign data_out    = data_out_q;
  assign frame_valid = frame_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// Scoreboard bench: an even-parity and an odd-parity checker fed with directed and random frames.
module tb_serial_parity_frame_checker;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       bi_e, bv_e, bi_o, bv_o;
  logic [7:0] dout_e, dout_o, ec_e, ec_o;
  logic       fv_e, fv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  exp_t q_e[$];
  exp_t q_o[$];
  int   ecnt[2];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_parity_frame_checker #(.DATA_W(8), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .bit_in(bi_e), .bit_valid(bv_e),
    .data_out(dout_e), .frame_valid(fv_e), .parity_err(pe_e),
    .framing_err(fe_e), .busy(busy_e), .err_count(ec_e)
  );

  serial_parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .bit_in(bi_o), .bit_valid(bv_o),
    .data_out(dout_o), .frame_valid(fv_o), .parity_err(pe_o),
    .framing_err(fe_o), .busy(busy_o), .err_count(ec_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input int sel, input logic [7:0] d, input logic pe,
                             input logic fe, input logic [7:0] ec);
    exp_t e;
    string tag;
    tag = (sel == 0) ? "even" : "odd";
    if ((sel == 0 && q_e.size() == 0) || (sel == 1 && q_o.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected_frame: got frame_valid data=%0h expected no frame", tag, d);
    end else begin
      e = (sel == 0) ? q_e.pop_front() : q_o.pop_front();
      chk({tag, "_data"}, 32'(d), 32'(e.data));
      chk({tag, "_parity_err"}, 32'(pe), 32'(e.pe));
      chk({tag, "_framing_err"}, 32'(fe), 32'(e.fe));
      chk({tag, "_err_count"}, 32'(ec), 32'(e.ec));
    end
  endtask

  // Monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (fv_e === 1'b1) check_frame(0, dout_e, pe_e, fe_e, ec_e);
    if (fv_o === 1'b1) check_frame(1, dout_o, pe_o, fe_o, ec_o);
  end

  task automatic set_in(input int sel, input logic b, input logic v);
    if (sel == 0) begin
      bi_e = b;
      bv_e = v;
    end else begin
      bi_o = b;
      bv_o = v;
    end
  endtask

  task automatic drive_bit(input int sel, input logic b, input bit gap);
    if (gap) begin
      set_in(sel, 1'($urandom), 1'b0);
      @(posedge clk);
      #1;
    end
    set_in(sel, b, 1'b1);
    @(posedge clk);
    #1;
    set_in(sel, 1'($urandom), 1'b0);
  endtask

  // mode: 0 = no gaps, 1 = idle cycle before every bit, 2 = random idle cycles
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic stop, input int mode);
    exp_t e;
    bit   g;
    int   ones;
    ones   = $countones(data) + int'(pbit);
    e.data = data;
    e.pe   = ((ones % 2) == 1) ^ (sel == 1);
    e.fe   = !stop;
`ifdef PARITY_ERR_COUNT_EN
    if ((e.pe || e.fe) && ecnt[sel] < 255) ecnt[sel]++;
`endif
    e.ec = 8'(ecnt[sel]);
    if (sel == 0) q_e.push_back(e);
    else          q_o.push_back(e);
    for (int i = 0; i < 11; i++) begin
      logic b;
      if (i == 0)       b = 1'b0;
      else if (i <= 8)  b = data[i-1];
      else if (i == 9)  b = pbit;
      else              b = stop;
      g = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
      drive_bit(sel, b, g);
    end
  endtask

  function automatic logic good_parity(input int sel, input logic [7:0] d);
    return (^d) ^ (sel == 1);
  endfunction

  initial begin
    reset = 1'b1;
    set_in(0, 1'b1, 1'b0);
    set_in(1, 1'b1, 1'b0);
    ecnt[0] = 0;
    ecnt[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(dout_e), 32'h0);
    chk("rst_fv", 32'({fv_e, fv_o}), 32'h0);
    chk("rst_errs", 32'({pe_e, fe_e, pe_o, fe_o}), 32'h0);
    chk("rst_busy", 32'({busy_e, busy_o}), 32'h0);
    chk("rst_err_count", 32'({ec_e, ec_o}), 32'h0);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
    send_frame(0, 8'h07, 1'b1, 1'b0, 1);
    send_frame(1, 8'h00, 1'b1, 1'b1, 0);
    send_frame(1, 8'hFF, 1'b1, 1'b1, 0);

    // Partial frame then reset: no frame may be reported and everything clears.
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'(8'h3C >> i), 1'b0);
    @(negedge clk);
    chk("busy_mid_frame", 32'(busy_e), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ecnt[0] = 0;
    ecnt[1] = 0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_e), 32'h0);
    chk("midrst_data", 32'(dout_e), 32'h0);
    chk("midrst_flags", 32'({fv_e, pe_e, fe_e}), 32'h0);
    chk("midrst_err_count", 32'({ec_e, ec_o}), 32'h0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0);

    for (int n = 0; n < 80; n++) begin
      int         sel;
      logic [7:0] d;
      logic       p, s;
      sel = n % 2;
      d   = 8'($urandom);
      p   = ($urandom_range(0, 3) == 0) ? ~good_parity(sel, d) : good_parity(sel, d);
      s   = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(0, 2)) drive_bit(sel, 1'b1, 1'b0);
      send_frame(sel, d, p, s, int'($urandom_range(0, 2)));
    end

    for (int n = 0; n < 260; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(0, d, ~good_parity(0, d), 1'b1, 0);
    end
    @(negedge clk);
`ifdef PARITY_ERR_COUNT_EN
    chk("err_count_saturated", 32'(ec_e), 32'd255);
`else
    chk("err_count_tied_zero", 32'(ec_e), 32'd0);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("even_missing_frames", 32'(q_e.size()), 32'd0);
    chk("odd_missing_frames", 32'(q_o.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
